// File: rtl/tlc_pkg.sv
// Shared definitions for the multiphase traffic light controller.
//   - tlc_state_t : FSM state encoding (ALLRED=0, GREEN=1, YELLOW=2, WALK=3)
//   - LAMP_*      : one-hot lamp codes for a single 3-bit signal field
//   - cnt_width() : dwell-counter width derived from the duration parameters
package tlc_pkg;

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    WALK   = 3'd3
  } tlc_state_t;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  // $clog2 of the longest duration, never below one bit so a design with
  // every duration equal to 1 still has a legal counter.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Circular-priority demand search for the traffic light controller.
// Purely combinational.
//   i_req        : per-phase demand
//   i_phase      : currently active / last-served phase
//   o_next_phase : first phase after i_phase (wrapping) with demand;
//                  i_phase itself when nothing else is requesting
//   o_any_other  : some phase other than i_phase has demand
module tlc_rr_arbiter #(
  parameter int NUM_PHASES = 4,
  parameter int PW         = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] i_req,
  input  logic [PW-1:0]         i_phase,
  output logic [PW-1:0]         o_next_phase,
  output logic                  o_any_other
);

  int   w_idx;
  logic w_found;

  // Search offsets 1..NUM_PHASES; the last offset lands on i_phase itself,
  // which yields the "return to the same phase" result for free.
  always_comb begin
    o_next_phase = i_phase;
    w_found      = 1'b0;
    w_idx        = 0;
    for (int i = 1; i <= NUM_PHASES; i++) begin
      w_idx = (int'(i_phase) + i) % NUM_PHASES;
      if (!w_found && i_req[w_idx]) begin
        o_next_phase = w_idx[PW-1:0];
        w_found      = 1'b1;
      end
    end
  end

  always_comb begin
    o_any_other = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if ((i != int'(i_phase)) && i_req[i]) o_any_other = 1'b1;
    end
  end

endmodule

// File: rtl/tlc_multiphase.sv
// Multiphase Moore traffic light controller with demand-actuated phase
// skipping and rest-in-green. Optional pedestrian walk phase is enabled by
// defining the macro TLC_PED_EN.
//   clk     : clock
//   rst     : asynchronous active-low reset
//   req     : per-phase vehicle demand (registered before use)
//   ped_req : pedestrian button pulse            (TLC_PED_EN only)
//   lights  : 3 bits per phase, 001 green / 010 yellow / 100 red
//   walk    : pedestrian walk lamp               (TLC_PED_EN only)
//   phase   : active / last-served phase index
//   state   : current FSM state encoding
module tlc_multiphase
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         req,
`ifdef TLC_PED_EN
  input  logic                          ped_req,
  output logic                          walk,
`endif
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [2:0]                    state
);

  localparam int PW    = $clog2(NUM_PHASES);
  localparam int CNT_W = cnt_width(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, PED_CYC);

  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
`ifdef TLC_PED_EN
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);
`endif

  tlc_state_t            r_state;
  tlc_state_t            w_next_state;
  logic [PW-1:0]         r_phase;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_first;   // forces phase 0 on the first green after reset
  logic [NUM_PHASES-1:0] r_req;
  logic [PW-1:0]         w_next_phase;
  logic                  w_any_other;
  logic                  w_ped_pending;
`ifdef TLC_PED_EN
  logic                  r_ped_pending;
`endif

  tlc_rr_arbiter #(
    .NUM_PHASES (NUM_PHASES),
    .PW         (PW)
  ) u_arb (
    .i_req        (r_req),
    .i_phase      (r_phase),
    .o_next_phase (w_next_phase),
    .o_any_other  (w_any_other)
  );

`ifdef TLC_PED_EN
  assign w_ped_pending = r_ped_pending;
`else
  assign w_ped_pending = 1'b0;
`endif

  // State register, dwell counter, phase and demand sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ALLRED;
      r_phase <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_req   <= '0;
    end else begin
      r_state <= w_next_state;
      r_req   <= req;
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (!((r_state == GREEN) && (r_cnt == GREEN_LAST))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == ALLRED) && (w_next_state == GREEN)) begin
        r_phase <= r_first ? '0 : w_next_phase;
        r_first <= 1'b0;
      end
    end
  end

`ifdef TLC_PED_EN
  // Set wins over the clear-on-WALK-entry so a press on that same edge
  // is kept for the next cycle rather than lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ped_pending <= 1'b0;
    end else if (ped_req) begin
      r_ped_pending <= 1'b1;
    end else if ((r_state == YELLOW) && (w_next_state == WALK)) begin
      r_ped_pending <= 1'b0;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ALLRED: if (r_cnt == ALLRED_LAST) w_next_state = GREEN;
      GREEN:  if ((r_cnt == GREEN_LAST) && (w_any_other || w_ped_pending))
                w_next_state = YELLOW;
`ifdef TLC_PED_EN
      YELLOW: if (r_cnt == YELLOW_LAST) w_next_state = w_ped_pending ? WALK : ALLRED;
      WALK:   if (r_cnt == PED_LAST) w_next_state = ALLRED;
`else
      YELLOW: if (r_cnt == YELLOW_LAST) w_next_state = ALLRED;
`endif
      default: w_next_state = ALLRED;
    endcase
  end

  // Moore output decode
  always_comb begin
    lights = {NUM_PHASES{LAMP_OFF}};
    for (int i = 0; i < NUM_PHASES; i++) begin
      lights[3*i +: 3] = LAMP_RED;
      if (i == int'(r_phase)) begin
        if (r_state == GREEN)       lights[3*i +: 3] = LAMP_GREEN;
        else if (r_state == YELLOW) lights[3*i +: 3] = LAMP_YELLOW;
      end
    end
  end

`ifdef TLC_PED_EN
  assign walk = (r_state == WALK);
`endif
  assign phase = r_phase;
  assign state = r_state;

endmodule

// File: tb/tb_tlc_multiphase.sv
// Directed bench for tlc_multiphase (NUM_PHASES=4, GREEN=8, YELLOW=3,
// ALLRED=2, PED=6). Pedestrian section is built only with TLC_PED_EN.
// Inputs are driven 1 ns after a rising edge and outputs are sampled there.
// A req change driven in one cycle is registered on the next edge and acted
// on at the edge after that.
module tb_tlc_multiphase;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] lights;
  logic [1:0]  phase;
  logic [2:0]  state;
`ifdef TLC_PED_EN
  logic        ped_req;
  logic        walk;
`endif

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [11:0] ALL_RED = 12'h924;

  tlc_multiphase #(
    .NUM_PHASES (4),
    .GREEN_CYC  (8),
    .YELLOW_CYC (3),
    .ALLRED_CYC (2),
    .PED_CYC    (6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef TLC_PED_EN
    .ped_req (ped_req),
    .walk    (walk),
`endif
    .lights  (lights),
    .phase   (phase),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All fields red except phase ph, which shows code.
  function automatic logic [11:0] lamps(input int ph, input logic [2:0] code);
    logic [11:0] v;
    v = ALL_RED;
    v[3*ph +: 3] = code;
    return v;
  endfunction

  // Starts on the first green cycle of cur; checks the rest of the minimum
  // green, yellow, all-red and the first green of nxt. req is changed to
  // req_y on the first yellow cycle.
  task automatic serve(input int cur, input int nxt, input logic [3:0] req_y);
    for (int k = 0; k < 7; k++) begin
      tick(); chk("green_hold", lights, lamps(cur, 3'b001));
    end
    for (int k = 0; k < 3; k++) begin
      tick(); chk("yellow", lights, lamps(cur, 3'b010));
      if (k == 0) req = req_y;
    end
    for (int k = 0; k < 2; k++) begin
      tick(); chk("allred", lights, ALL_RED); chk("allred_phase", phase, cur);
    end
    tick();
    chk("green_next", lights, lamps(nxt, 3'b001));
    chk("phase_next", phase, nxt);
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b0000;
`ifdef TLC_PED_EN
    ped_req = 1'b0;
`endif

    // Reset and first green
    repeat (3) tick();
    chk("in_reset_lights", lights, ALL_RED);
    rst = 1'b1;
    chk("rst_lights", lights, 12'h924);
    chk("rst_phase", phase, 0);
    chk("rst_state", state, 0);
    tick(); chk("first_allred", lights, 12'h924);
    tick(); chk("first_green", lights, 12'h921);
    chk("first_phase", phase, 0);
    chk("first_state", state, 1);

    // Rest in green with no demand
    for (int k = 0; k < 50; k++) begin
      tick(); chk("rest_green", lights, 12'h921);
    end
    req = 4'b0100;
    tick(); chk("req_latency", lights, 12'h921);
    tick(); chk("rest_yellow", lights, 12'h922); chk("yellow_state", state, 2);
    tick(); chk("rest_yellow2", lights, 12'h922);
    tick(); chk("rest_yellow3", lights, 12'h922);
    tick(); chk("rest_allred", lights, 12'h924);
    tick(); chk("rest_allred2", lights, 12'h924);
    tick(); chk("ph2_green", lights, 12'h864); chk("ph2_phase", phase, 2);

    // Circular skip: 2 -> 3 -> 0 -> 1
    req = 4'b1011;
    serve(2, 3, 4'b1011);
    chk("ph3_lights", lights, 12'h324);
    serve(3, 0, 4'b1011);
    serve(0, 1, 4'b1011);
    chk("ph1_lights", lights, 12'h90C);

    // Demand drops during yellow: timing unchanged, no demand -> back to 1
    serve(1, 1, 4'b0000);

`ifdef TLC_PED_EN
    // Pedestrian pulse during rest in phase 1 green
    ped_req = 1'b1;
    tick(); ped_req = 1'b0;
    chk("ped_green", lights, lamps(1, 3'b001));
    for (int k = 0; k < 6; k++) begin
      tick(); chk("ped_green_hold", lights, lamps(1, 3'b001));
    end
    for (int k = 0; k < 3; k++) begin
      tick(); chk("ped_yellow", lights, lamps(1, 3'b010));
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("walk_lights", lights, ALL_RED);
      chk("walk_lamp", walk, 1);
      chk("walk_state", state, 3);
    end
    for (int k = 0; k < 2; k++) begin
      tick(); chk("ped_allred", lights, ALL_RED); chk("walk_off", walk, 0);
    end
    tick(); chk("ped_regreen", lights, lamps(1, 3'b001)); chk("ped_phase", phase, 1);
`endif

    // Mid-operation asynchronous reset during phase 1 yellow
    req = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      tick(); chk("pre_rst_green", lights, 12'h90C);
    end
    tick(); chk("pre_rst_yellow", lights, 12'h914);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_lights", lights, 12'h924);
    chk("async_rst_phase", phase, 0);
    chk("async_rst_state", state, 0);
    req = 4'b0100;
    tick(); tick();
    chk("held_rst_lights", lights, 12'h924);
    rst = 1'b1;
    tick(); chk("post_rst_allred", lights, 12'h924);
    tick();
    chk("post_rst_green", lights, 12'h921);
    chk("post_rst_phase", phase, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
